// File: rtl/seq5b_pkg.sv
// Shared types and the next-word predictor for the 5-bit sequence-generator link.
package seq5b_pkg;

    localparam int unsigned SEQ5B_W = 5;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } seq5b_state_e;

    function automatic logic [SEQ5B_W-1:0] seq5b_next(input logic [SEQ5B_W-1:0] s);
        logic [SEQ5B_W-1:0] n;
        n[0] = s[4];
        n[1] = s[0];
        n[2] = s[1];
        n[3] = s[4] | s[2];
        n[4] = ~(s[4] ^ s[3]);
        return n;
    endfunction

endpackage

// File: rtl/seq5b_checker.sv
// Self-synchronizing receive checker for the 5-bit sequence link: hunts for lock, then counts errors.
// Optional first-error capture outputs when SEQ5B_CHK_FIRST_ERR_EN is defined.
module seq5b_checker
    import seq5b_pkg::*;
#(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned ERR_W      = 16
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic [SEQ5B_W-1:0] din,
    input  logic               clr_cnt,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_cnt
`ifdef SEQ5B_CHK_FIRST_ERR_EN
    ,
    output logic               first_vld,
    output logic [SEQ5B_W-1:0] first_got,
    output logic [SEQ5B_W-1:0] first_exp
`endif
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned UW = $clog2(UNLOCK_CNT + 1);

    seq5b_state_e       state_q, state_d;
    logic [MW-1:0]      match_cnt_q, match_cnt_d;
    logic [UW-1:0]      miss_cnt_q, miss_cnt_d;
    logic [SEQ5B_W-1:0] prev_q, prev_d;
    logic               prev_vld_q, prev_vld_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic [SEQ5B_W-1:0] expected;
    logic               match;
    logic               counted_err;

    assign expected = seq5b_next(prev_q);
    assign match    = (din == expected);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        counted_err = 1'b0;

        if (en) begin
            prev_d     = din;
            prev_vld_d = 1'b1;
            if (prev_vld_q) begin
                unique case (state_q)
                    HUNT: begin
                        if (!match) begin
                            match_cnt_d = '0;
                        end else if (match_cnt_q + MW'(1) == MW'(LOCK_CNT)) begin
                            state_d     = LOCK;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MW'(1);
                        end
                    end
                    LOCK: begin
                        if (match) begin
                            miss_cnt_d = '0;
                        end else begin
                            counted_err = 1'b1;
                            err_pulse_d = 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_d = err_cnt_q + ERR_W'(1);
                            end
                            if (miss_cnt_q + UW'(1) == UW'(UNLOCK_CNT)) begin
                                state_d     = HUNT;
                                match_cnt_d = '0;
                                miss_cnt_d  = '0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + UW'(1);
                            end
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end

        // Clear beats a coincident increment; the pulse still reports the error.
        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= HUNT;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = (state_q == LOCK);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef SEQ5B_CHK_FIRST_ERR_EN
    logic               first_vld_q;
    logic [SEQ5B_W-1:0] first_got_q, first_exp_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            first_vld_q <= 1'b0;
            first_got_q <= '0;
            first_exp_q <= '0;
        end else if (clr_cnt) begin
            first_vld_q <= 1'b0;
            first_got_q <= '0;
            first_exp_q <= '0;
        end else if (counted_err && !first_vld_q) begin
            first_vld_q <= 1'b1;
            first_got_q <= din;
            first_exp_q <= expected;
        end
    end

    assign first_vld = first_vld_q;
    assign first_got = first_got_q;
    assign first_exp = first_exp_q;
`else
    logic unused_counted_err;
    assign unused_counted_err = counted_err;
`endif

endmodule

// File: tb/tb_seq5b_checker.sv
// Randomized self-checking bench for seq5b_checker against a word-level reference model.
module tb_seq5b_checker;

    localparam int TB_ERR_W = 4;
    localparam int ERR_MAX  = (1 << TB_ERR_W) - 1;

    logic                clk = 1'b0;
    logic                rst_b;
    logic                en;
    logic [4:0]          din;
    logic                clr_cnt;
    logic                locked;
    logic                err_pulse;
    logic [TB_ERR_W-1:0] err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state, in plain integers.
    int m_prev, m_have_prev, m_locked, m_good_run, m_bad_run, m_errs, m_pulse;
    int last_sent;

    seq5b_checker #(
        .LOCK_CNT   (4),
        .UNLOCK_CNT (3),
        .ERR_W      (TB_ERR_W)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .en        (en),
        .din       (din),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int predict(input int s);
        int b4, b3, b2, b1, b0;
        b4 = (s / 16) % 2; b3 = (s / 8) % 2; b2 = (s / 4) % 2; b1 = (s / 2) % 2; b0 = s % 2;
        return 16 * (1 - (b4 ^ b3)) + 8 * (b4 | b2) + 4 * b1 + 2 * b0 + b4;
    endfunction

    function automatic void model_reset();
        m_prev = 0; m_have_prev = 0; m_locked = 0;
        m_good_run = 0; m_bad_run = 0; m_errs = 0; m_pulse = 0;
    endfunction

    function automatic void model_step(input int e, input int d, input int c);
        m_pulse = 0;
        if (e != 0) begin
            if (m_have_prev != 0) begin
                if (m_locked == 0) begin
                    m_good_run = (d == predict(m_prev)) ? m_good_run + 1 : 0;
                    if (m_good_run == 4) begin
                        m_locked = 1; m_good_run = 0; m_bad_run = 0;
                    end
                end else if (d == predict(m_prev)) begin
                    m_bad_run = 0;
                end else begin
                    m_pulse = 1;
                    if (m_errs < ERR_MAX) m_errs++;
                    m_bad_run++;
                    if (m_bad_run == 3) begin
                        m_locked = 0; m_good_run = 0; m_bad_run = 0;
                    end
                end
            end
            m_prev = d;
            m_have_prev = 1;
        end
        if (c != 0) m_errs = 0;
    endfunction

    task automatic step(input logic e, input logic [4:0] d, input logic c);
        en = e; din = d; clr_cnt = c;
        @(posedge clk);
        model_step(int'(e), int'(d), int'(c));
        if (e) last_sent = int'(d);
        #1;
        check("locked", int'(locked), m_locked);
        check("err_pulse", int'(err_pulse), m_pulse);
        check("err_cnt", int'(err_cnt), m_errs);
    endtask

    task automatic do_reset();
        en = 1'b0; din = '0; clr_cnt = 1'b0;
        rst_b = 1'b0;
        model_reset();
        last_sent = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", int'(locked), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_err_pulse", int'(err_pulse), 0);
        rst_b = 1'b1;
    endtask

    initial begin
        int word;
        do_reset();

        // Idle with en low: nothing may move.
        repeat (5) step(1'b0, 5'h15, 1'b0);

        // Acquire lock on 00,10,09,02,14 then continue.
        step(1'b1, 5'h00, 1'b0);
        step(1'b1, 5'h10, 1'b0);
        step(1'b1, 5'h09, 1'b0);
        step(1'b1, 5'h02, 1'b0);
        check("not_yet_locked", int'(locked), 0);
        step(1'b1, 5'h14, 1'b0);
        check("locked_after_5", int'(locked), 1);
        step(1'b1, 5'h09, 1'b0);

        // Single corrupted word costs two errors because prev re-seeds.
        step(1'b1, 5'h0C, 1'b0);
        check("inject_pulse", int'(err_pulse), 1);
        step(1'b1, 5'h14, 1'b0);
        check("resync_err_cnt", int'(err_cnt), 2);
        step(1'b1, 5'h09, 1'b0);
        check("still_locked", int'(locked), 1);

        // Clear together with a counted error.
        step(1'b1, 5'h0C, 1'b1);
        check("clr_wins", int'(err_cnt), 0);
        check("clr_pulse", int'(err_pulse), 1);
        step(1'b1, 5'h14, 1'b0);

        // Three consecutive bad words drop lock; further errors are not counted.
        step(1'b1, 5'h00, 1'b0);
        check("fell_out", int'(locked), 0);
        step(1'b1, 5'h1B, 1'b0);
        step(1'b1, 5'h07, 1'b0);
        check("hunt_no_count", int'(err_cnt), 2);

        // 1F is a fixed point of the map; reset mid-stream clears everything at once.
        do_reset();
        repeat (6) step(1'b1, 5'h1F, 1'b0);
        check("locked_1f", int'(locked), 1);
        step(1'b1, 5'h03, 1'b0);
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        check("async_locked", int'(locked), 0);
        check("async_pulse", int'(err_pulse), 0);
        check("async_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        rst_b = 1'b1;
        last_sent = 0;

        // Random stream: mostly correct continuation, occasional corruption, idle and clear.
        for (int i = 0; i < 2000; i++) begin
            logic e, c;
            e = ($urandom_range(0, 9) != 0);
            c = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 5) == 0) word = int'($urandom_range(0, 31));
            else word = predict(last_sent);
            step(e, 5'(word), c);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
